pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Parametrised program-counter sequencer for the RISC core. It generalises the fixed 13-bit load/increment counter with a configurable address width, increment step and reset vector. It adds a stall input, a jump-and-link call path and a hardware return-address stack of configurable depth. It sits between the instruction decoder, which supplies the control strobes and target address, and the instruction memory address port.

## Interface
- `AW`, 13, address width in bits.
- `DEPTH`, 4, number of return-stack entries; must be ≥ 1.
- `STEP`, 1, increment applied per advance; must be < 2^AW.
- `RESET_ADDR`, 0, value loaded into `pc_addr` on reset.

- `clock`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  advance enable; low = hold all state (stall).
- `load`  in  1  jump: `pc_addr` ← `ir_addr`.
- `call`  in  1  call: push `pc_addr`+`STEP`, then `pc_addr` ← `ir_addr`.
- `ret`  in  1  return: `pc_addr` ← top of stack, then pop.
- `ir_addr`  in  AW  jump/call target address.
- `pc_addr`  out  AW  current program counter (registered).
- `stack_full`  out  1  stack holds `DEPTH` entries.
- `stack_empty`  out  1  stack holds 0 entries.
- `stack_err`  out  1  sticky flag: overflow or underflow occurred.

## Operation
- Reset values: `pc_addr`=`RESET_ADDR`, stack count=0, `stack_err`=0. This gives `stack_empty`=1 and `stack_full`=0. Stack entry contents are don't-care.
- `en`=0: no state change; all strobes are ignored.
- `en`=1: exactly one action, chosen by fixed priority `call` > `ret` > `load` > increment. Strobes that lose priority are ignored.
- Increment: `pc_addr` ← (`pc_addr`+`STEP`) mod 2^AW. Wrap-around from the top address to a low address is legal and silent.
- Call with stack not full: push (`pc_addr`+`STEP`) mod 2^AW; `pc_addr` ← `ir_addr`.
- Call with stack full: the jump still happens, but nothing is pushed. Existing entries are unchanged and `stack_err` is set.
- Ret with stack not empty: `pc_addr` ← top entry; count decrements.
- Ret with stack empty: treated as an increment and `stack_err` is set.
- Load: `pc_addr` ← `ir_addr`; the stack is untouched.
- `stack_err` stays set until `rst`.
- The stack is strictly LIFO: entries are indexed by count and no shift register is used.

## Timing
- Every output is registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- Latency is one cycle: an action sampled on edge N is visible on `pc_addr`, the flags and `stack_err` just after edge N.
- The strobes and `ir_addr` are sampled only at a rising edge with `en`=1. They must be stable across that edge.
- Back-to-back calls and returns on consecutive cycles are fully supported, with no bubbles.
- `rst` asserted at any time, including mid-sequence or while stalled, forces the reset values immediately, without waiting for a clock edge. The first action after deassertion is taken on the first rising edge with `rst`=0.

## Structure
- Package `pc_pkg` holds the default constants (`AW`=13, `DEPTH`=4, `RESET_ADDR`) and the encoding of the action select (HOLD, INC, LOAD, CALL, RET) shared with the decoder.
- Sub-module `ret_stack`, a parametrised LIFO, provides:
  - inputs: push, pop, push data;
  - outputs: top, full, empty;
  - a count register of width clog2(`DEPTH`+1).
- The top level holds the priority decode, the PC register and the sticky error flag.

## Test plan
- Reset and increment: assert `rst`, release, hold `en`=1 with no strobes for 5 cycles. `pc_addr` must read 0, 1, 2, 3, 4, 5, with `stack_empty`=1.
- Stall and jump: at `pc_addr`=3, drive `en`=0 for 3 cycles, so `pc_addr` holds at 3. Then drive `en`=1, `load`=1, `ir_addr`=0x1A0. The next cycle `pc_addr` must be 0x1A0, then 0x1A1.
- Call and return: at `pc_addr`=0x010, call 0x100, so `pc_addr`=0x100 and `stack_empty`=0. Two increments give 0x102. A return then gives `pc_addr`=0x011 and `stack_empty`=1.
- Nested overflow (`DEPTH`=4): 5 calls from addresses 0x10, 0x20, 0x30, 0x40, 0x50.
  - `stack_full`=1 after the 4th call; `stack_err`=1 after the 5th.
  - 4 returns must then yield 0x41, 0x31, 0x21, 0x11.
- Underflow, priority and wrap:
  - From `pc_addr`=0x1FFF with an empty stack, drive `ret`. Expect `pc_addr`=0x0000 and `stack_err`=1.
  - Next drive `call`+`load`, `ir_addr`=0x055. Expect `pc_addr`=0x055 and one entry pushed, holding 0x0001.
- Asynchronous reset mid-sequence: with 2 entries on the stack and `stack_err`=1, pulse `rst` between clock edges. `pc_addr`=0, `stack_empty`=1 and `stack_err`=0 must all appear before the next edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and action-select encoding for the program-counter sequencer
// and the instruction decoder that drives it.
package pc_pkg;

  localparam int          PC_AW         = 13;
  localparam int          PC_DEPTH      = 4;
  localparam int unsigned PC_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_INC  = 3'd1,
    ACT_LOAD = 3'd2,
    ACT_CALL = 3'd3,
    ACT_RET  = 3'd4
  } pc_act_e;

  // Fixed priority: call > ret > load > increment; nothing happens while stalled.
  function automatic pc_act_e decode_act(input logic en, input logic call,
                                         input logic ret, input logic load);
    pc_act_e act;
    act = ACT_HOLD;
    if (en) begin
      if (call)      act = ACT_CALL;
      else if (ret)  act = ACT_RET;
      else if (load) act = ACT_LOAD;
      else           act = ACT_INC;
    end
    return act;
  endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO indexed by an occupancy count; push is dropped when full,
// pop is dropped when empty. Entry storage is not reset.
module ret_stack #(
  parameter int AW    = 13,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          full,
  output logic          empty
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] count;
  logic [AW-1:0] mem [2**IW];
  logic [IW-1:0] top_idx;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = empty ? '0 : IW'(count - CW'(1));
  assign top     = mem[top_idx];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[IW'(count)] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: prioritised jump/call/return/increment with stall,
// a hardware return-address stack and a sticky stack-error flag.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int          AW         = PC_AW,
  parameter int          DEPTH      = PC_DEPTH,
  parameter int unsigned STEP       = 1,
  parameter int unsigned RESET_ADDR = PC_RESET_ADDR
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] ir_addr,
  output logic [AW-1:0] pc_addr,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          stack_err
);

  localparam logic [AW-1:0] STEP_V  = AW'(STEP);
  localparam logic [AW-1:0] RESET_V = AW'(RESET_ADDR);

  pc_act_e       act;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] stk_top;
  logic          stk_push;
  logic          stk_pop;
  logic          err_set;

  assign pc_inc = pc_addr + STEP_V;

  always_comb begin
    act      = decode_act(en, call, ret, load);
    pc_next  = pc_addr;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    err_set  = 1'b0;
    unique case (act)
      ACT_CALL: begin
        pc_next  = ir_addr;
        stk_push = !stack_full;
        err_set  = stack_full;
      end
      ACT_RET: begin
        // An underflowing return degrades to a plain increment.
        pc_next = stack_empty ? pc_inc : stk_top;
        stk_pop = !stack_empty;
        err_set = stack_empty;
      end
      ACT_LOAD: pc_next = ir_addr;
      ACT_INC:  pc_next = pc_inc;
      default:  pc_next = pc_addr;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      pc_addr   <= RESET_V;
      stack_err <= 1'b0;
    end else begin
      pc_addr <= pc_next;
      if (err_set) stack_err <= 1'b1;
    end
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clock     (clock),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random strobes, checked
// against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

  localparam int          AW    = 13;
  localparam int          DEPTH = 4;
  localparam int unsigned STEP  = 1;
  localparam int unsigned MODV  = 1 << AW;

  logic          clock = 1'b0;
  logic          rst   = 1'b1;
  logic          en    = 1'b0;
  logic          load  = 1'b0;
  logic          call  = 1'b0;
  logic          ret   = 1'b0;
  logic [AW-1:0] ir_addr = '0;
  logic [AW-1:0] pc_addr;
  logic          stack_full;
  logic          stack_empty;
  logic          stack_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned m_pc;
  int unsigned m_stack[$];
  bit          m_err;

  pc_sequencer #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .STEP       (STEP),
    .RESET_ADDR (0)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .call        (call),
    .ret         (ret),
    .ir_addr     (ir_addr),
    .pc_addr     (pc_addr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc_addr),     m_pc);
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".err"},   32'(stack_err),   32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_stack.delete();
    m_err = 1'b0;
  endtask

  // One clock of the sequencer, expressed as the rule set it must obey.
  task automatic model_step(input bit e, input bit c, input bit r, input bit l, input int unsigned ir);
    if (!e) return;
    if (c) begin
      if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + STEP) % MODV);
      else m_err = 1'b1;
      m_pc = ir;
    end else if (r) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else begin
        m_pc  = (m_pc + STEP) % MODV;
        m_err = 1'b1;
      end
    end else if (l) begin
      m_pc = ir;
    end else begin
      m_pc = (m_pc + STEP) % MODV;
    end
  endtask

  task automatic step(input string tag, input bit e, input bit c, input bit r, input bit l,
                      input int unsigned ir);
    @(negedge clock);
    en = e; call = c; ret = r; load = l; ir_addr = AW'(ir);
    @(posedge clock);
    model_step(e, c, r, l, ir);
    #1;
    check_all(tag);
  endtask

  // Reset asserted and released between two rising edges.
  task automatic pulse_reset(input string tag);
    @(negedge clock);
    en = 1'b0; call = 1'b0; ret = 1'b0; load = 1'b0;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".pc0"}, 32'(pc_addr), 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b0;

    // Reset and increment
    for (int i = 1; i <= 5; i++) begin
      step("inc", 1, 0, 0, 0, 0);
      check("inc.val", 32'(pc_addr), 32'(i));
    end

    // Stall and jump
    pulse_reset("rst_b");
    repeat (3) step("inc3", 1, 0, 0, 0, 0);
    repeat (3) step("stall", 0, 1, 1, 1, 32'h0AA);
    check("stall.hold", 32'(pc_addr), 32'h3);
    step("jump", 1, 0, 0, 1, 32'h1A0);
    check("jump.val", 32'(pc_addr), 32'h1A0);
    step("jump_inc", 1, 0, 0, 0, 0);
    check("jump_inc.val", 32'(pc_addr), 32'h1A1);

    // Call and return
    step("to10", 1, 0, 0, 1, 32'h010);
    step("call", 1, 1, 0, 0, 32'h100);
    check("call.val", 32'(pc_addr), 32'h100);
    step("cinc", 1, 0, 0, 0, 0);
    step("cinc", 1, 0, 0, 0, 0);
    step("ret", 1, 0, 1, 0, 0);
    check("ret.val", 32'(pc_addr), 32'h011);

    // Nested overflow
    step("to10b", 1, 0, 0, 1, 32'h010);
    for (int i = 2; i <= 6; i++) step("ncall", 1, 1, 0, 0, 32'(i * 16));
    check("ovf.full", 32'(stack_full), 32'h1);
    check("ovf.err", 32'(stack_err), 32'h1);
    for (int i = 4; i >= 1; i--) begin
      step("nret", 1, 0, 1, 0, 0);
      check("nret.val", 32'(pc_addr), 32'(i * 16 + 1));
    end

    // Underflow, priority and wrap
    pulse_reset("rst_c");
    step("to1fff", 1, 0, 0, 1, 32'h1FFF);
    step("uflow", 1, 0, 1, 0, 0);
    check("uflow.pc", 32'(pc_addr), 32'h0);
    check("uflow.err", 32'(stack_err), 32'h1);
    step("prio", 1, 1, 0, 1, 32'h055);
    check("prio.pc", 32'(pc_addr), 32'h055);
    step("prio_ret", 1, 0, 1, 0, 0);
    check("prio_ret.pc", 32'(pc_addr), 32'h001);

    // Asynchronous reset with two entries and the error flag set
    step("c1", 1, 1, 0, 0, 32'h300);
    step("c2", 1, 1, 0, 0, 32'h400);
    pulse_reset("async_rst");

    // Random strobes, with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 9) == 0) ? (MODV - 1 - $urandom_range(0, 2))
                                         : $urandom_range(0, MODV - 1));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
